feature_map_streamer: RTL and testbench

- Reader-side counterpart to the parallel-array matrix producers (conv2, maxpooling).
- Once the producer raises done, the block reads the held ROWS x COLS result matrix and emits it as a raster-order element stream over a valid/ready handshake.
- The stream carries row/column markers and feeds the downstream serial sink or the next layer's loader.
- Optional ReLU is applied on the way out.

---
 rtl/feature_map_streamer.sv | 113 +++++++++++
 tb/tb_feature_map_streamer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_map_streamer.sv
// Streams a held ROWS x COLS result matrix out in raster order over valid/ready,
// starting on a rise of the producer's done level, with optional ReLU on each element.
module feature_map_streamer #(
  parameter int ROWS      = 253,
  parameter int COLS      = 253,
  parameter int WIDTH_BIT = 16,
  parameter int RELU      = 0,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        done,
  input  logic signed [WIDTH_BIT-1:0] matrixIn [ROWS-1:0][COLS-1:0],
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [WIDTH_BIT-1:0] out_data,
  output logic                        out_last_col,
  output logic                        out_last,
  output logic [RW-1:0]               row_idx,
  output logic [CW-1:0]               col_idx,
  output logic                        busy,
  output logic                        frame_done
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                        state, state_n;
  logic                          done_q;
  logic                          start;
  logic                          valid_n, busy_n, fdone_n;
  logic signed [WIDTH_BIT-1:0]   data_n;
  logic [RW-1:0]                 row_n;
  logic [CW-1:0]                 col_n;

  function automatic logic signed [WIDTH_BIT-1:0] xform(input logic signed [WIDTH_BIT-1:0] x);
    if ((RELU != 0) && x[WIDTH_BIT-1])
      return '0;
    return x;
  endfunction

  assign out_last_col = (col_idx == CW'(COLS - 1));
  assign out_last     = out_last_col && (row_idx == RW'(ROWS - 1));
  // Only a fresh rise while idle starts a frame, so a done level held high cannot retrigger.
  assign start        = (state == IDLE) && done && !done_q;

  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      row_idx    <= '0;
      col_idx    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      done_q     <= done;
      out_valid  <= valid_n;
      out_data   <= data_n;
      row_idx    <= row_n;
      col_idx    <= col_n;
      busy       <= busy_n;
      frame_done <= fdone_n;
    end
  end

  always_comb begin
    state_n = state;
    valid_n = out_valid;
    busy_n  = busy;
    fdone_n = 1'b0;
    data_n  = out_data;
    row_n   = row_idx;
    col_n   = col_idx;
    case (state)
      IDLE: begin
        if (start) begin
          row_n   = '0;
          col_n   = '0;
          data_n  = xform(matrixIn[0][0]);
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            valid_n = 1'b0;
            busy_n  = 1'b0;
            fdone_n = 1'b1;
            row_n   = '0;
            col_n   = '0;
            state_n = IDLE;
          end else begin
            // The next element is fetched on the same edge that accepts the current one.
            if (out_last_col) begin
              col_n = '0;
              row_n = row_idx + RW'(1);
            end else begin
              col_n = col_idx + CW'(1);
            end
            data_n = xform(matrixIn[row_n][col_n]);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_feature_map_streamer.sv
// Directed bench for feature_map_streamer: a 3x3 plain instance, a 3x3 ReLU instance
// and a non-square 4x5 instance driven with random backpressure.
module tb_feature_map_streamer;

  logic clock;
  logic nreset;
  int   passed;
  int   total;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // 3x3, RELU=0
  logic               done_a, ready_a, valid_a, lc_a, last_a, busy_a, fd_a;
  logic signed [15:0] mat_a [2:0][2:0];
  logic signed [15:0] data_a;
  logic [1:0]         row_a, col_a;

  // 3x3, RELU=1
  logic               done_r, ready_r, valid_r, lc_r, last_r, busy_r, fd_r;
  logic signed [15:0] mat_r [2:0][2:0];
  logic signed [15:0] data_r;
  logic [1:0]         row_r, col_r;

  // 4x5, RELU=0
  logic               done_n, ready_n, valid_n, lc_n, last_n, busy_n, fd_n;
  logic signed [15:0] mat_n [3:0][4:0];
  logic signed [15:0] data_n;
  logic [1:0]         row_n;
  logic [2:0]         col_n;

  feature_map_streamer #(.ROWS(3), .COLS(3), .WIDTH_BIT(16), .RELU(0)) dut_a (
    .clock(clock), .nreset(nreset), .done(done_a), .matrixIn(mat_a), .out_ready(ready_a),
    .out_valid(valid_a), .out_data(data_a), .out_last_col(lc_a), .out_last(last_a),
    .row_idx(row_a), .col_idx(col_a), .busy(busy_a), .frame_done(fd_a));

  feature_map_streamer #(.ROWS(3), .COLS(3), .WIDTH_BIT(16), .RELU(1)) dut_r (
    .clock(clock), .nreset(nreset), .done(done_r), .matrixIn(mat_r), .out_ready(ready_r),
    .out_valid(valid_r), .out_data(data_r), .out_last_col(lc_r), .out_last(last_r),
    .row_idx(row_r), .col_idx(col_r), .busy(busy_r), .frame_done(fd_r));

  feature_map_streamer #(.ROWS(4), .COLS(5), .WIDTH_BIT(16), .RELU(0)) dut_n (
    .clock(clock), .nreset(nreset), .done(done_n), .matrixIn(mat_n), .out_ready(ready_n),
    .out_valid(valid_n), .out_data(data_n), .out_last_col(lc_n), .out_last(last_n),
    .row_idx(row_n), .col_idx(col_n), .busy(busy_n), .frame_done(fd_n));

  task automatic test_reset();
    total++;
    if ({valid_a, data_a, lc_a, last_a, row_a, col_a, busy_a, fd_a} !== 25'd0) begin
      $display("[TB] FAIL reset_a got %h expected 0",
               {valid_a, data_a, lc_a, last_a, row_a, col_a, busy_a, fd_a});
    end else passed++;
    total++;
    if ({valid_r, data_r, busy_r, fd_r, valid_n, data_n, busy_n, fd_n} !== 38'd0) begin
      $display("[TB] FAIL reset_rn got %h expected 0",
               {valid_r, data_r, busy_r, fd_r, valid_n, data_n, busy_n, fd_n});
    end else passed++;
    @(negedge clock);
    nreset = 1'b0;
    @(negedge clock);
    total++;
    if ({valid_a, busy_a, fd_a, row_a, col_a} !== 7'd0) begin
      $display("[TB] FAIL idle_after_reset got %b expected 0", {valid_a, busy_a, fd_a, row_a, col_a});
    end else passed++;
  endtask

  // Runs one frame on instance a; mode 0 = ready always 1, mode 1 = ready pattern 1,0,0.
  task automatic run_frame_a(input int mode, input string tag);
    int                 k;
    bit                 finished;
    bit                 hold;
    logic               rdy;
    logic signed [15:0] hd;
    logic [1:0]         hr, hc;
    k = 0;
    finished = 0;
    hold = 0;
    hd = '0;
    hr = '0;
    hc = '0;
    @(negedge clock);
    done_a = 1'b1;
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      @(negedge clock);
      if (k == 9) begin
        total++;
        if ({fd_a, valid_a, busy_a, row_a, col_a} !== 7'b1000000) begin
          $display("[TB] FAIL %s_frame_done got fd=%b v=%b b=%b r=%0d c=%0d expected fd=1 others 0",
                   tag, fd_a, valid_a, busy_a, row_a, col_a);
        end else passed++;
        finished = 1;
      end else begin
        total++;
        if (valid_a !== 1'b1 || fd_a !== 1'b0) begin
          $display("[TB] FAIL %s_valid k=%0d got v=%b fd=%b expected v=1 fd=0", tag, k, valid_a, fd_a);
        end else passed++;
        if (hold) begin
          total++;
          if (data_a !== hd || row_a !== hr || col_a !== hc) begin
            $display("[TB] FAIL %s_hold got %0d[%0d][%0d] expected %0d[%0d][%0d]",
                     tag, data_a, row_a, col_a, hd, hr, hc);
          end else passed++;
        end
        rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        ready_a = rdy;
        if (rdy) begin
          total++;
          if (data_a !== 16'(k) || row_a !== 2'(k / 3) || col_a !== 2'(k % 3) ||
              lc_a !== ((k % 3) == 2) || last_a !== (k == 8)) begin
            $display("[TB] FAIL %s_elem k=%0d got d=%0d r=%0d c=%0d lc=%b l=%b expected d=%0d r=%0d c=%0d lc=%b l=%b",
                     tag, k, data_a, row_a, col_a, lc_a, last_a, k, k / 3, k % 3, (k % 3) == 2, k == 8);
          end else passed++;
          k++;
        end
        hold = !rdy;
        hd = data_a;
        hr = row_a;
        hc = col_a;
      end
    end
    total++;
    if (!finished) begin
      $display("[TB] FAIL %s_timeout got %0d elements expected 9", tag, k);
    end else passed++;
    ready_a = 1'b1;
    @(negedge clock);
    total++;
    if (fd_a !== 1'b0) begin
      $display("[TB] FAIL %s_fd_pulse_width got %b expected 0", tag, fd_a);
    end else passed++;
  endtask

  task automatic test_stream_basic();
    ready_a = 1'b1;
    run_frame_a(0, "basic");
  endtask

  task automatic test_done_hold();
    bit active;
    active = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (valid_a || busy_a || fd_a) active = 1;
    end
    total++;
    if (active !== 1'b0) begin
      $display("[TB] FAIL done_hold_retrigger got %b expected 0", active);
    end else passed++;
    done_a = 1'b0;
    @(negedge clock);
    run_frame_a(1, "toggle");
  endtask

  task automatic test_reset_midframe();
    bit seen;
    bit active;
    seen = 0;
    active = 0;
    done_a = 1'b0;
    ready_a = 1'b1;
    @(negedge clock);
    done_a = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (valid_a && data_a == 16'sd4) seen = 1;
    end
    total++;
    if (!seen) begin
      $display("[TB] FAIL midframe_reach_elem4 got 0 expected 1");
    end else passed++;
    nreset = 1'b1;
    done_a = 1'b0;
    #1;
    total++;
    if ({valid_a, data_a, lc_a, last_a, row_a, col_a, busy_a, fd_a} !== 25'd0) begin
      $display("[TB] FAIL midframe_async_reset got %h expected 0",
               {valid_a, data_a, lc_a, last_a, row_a, col_a, busy_a, fd_a});
    end else passed++;
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (valid_a || busy_a || fd_a) active = 1;
    end
    total++;
    if (active !== 1'b0) begin
      $display("[TB] FAIL midframe_quiet_after_reset got %b expected 0", active);
    end else passed++;
    run_frame_a(0, "restart");
  endtask

  task automatic test_relu();
    int                 k;
    int                 fds;
    bit                 finished;
    logic signed [15:0] exp_r [9];
    exp_r = '{16'sd0, 16'sd3, 16'sd0, 16'sd0, 16'sd7, 16'sd0, 16'sd2, 16'sd0, 16'sd1};
    k = 0;
    fds = 0;
    finished = 0;
    ready_r = 1'b1;
    @(negedge clock);
    done_r = 1'b1;
    for (int cyc = 0; cyc < 30 && !finished; cyc++) begin
      @(negedge clock);
      if (fd_r) fds++;
      if (valid_r) begin
        total++;
        if (k > 8 || data_r !== exp_r[k]) begin
          $display("[TB] FAIL relu_elem k=%0d got %0d expected %0d", k, data_r, (k > 8) ? 0 : exp_r[k]);
        end else passed++;
        k++;
      end else if (k > 0) begin
        finished = 1;
      end
    end
    total++;
    if (k !== 9 || fds !== 1) begin
      $display("[TB] FAIL relu_count got n=%0d fd=%0d expected n=9 fd=1", k, fds);
    end else passed++;
  endtask

  task automatic test_random_ready();
    int                 k;
    int                 fds;
    bit                 finished;
    bit                 hold;
    logic               rdy;
    logic signed [15:0] hd;
    logic signed [15:0] expv;
    k = 0;
    fds = 0;
    finished = 0;
    hold = 0;
    hd = '0;
    ready_n = 1'b0;
    @(negedge clock);
    done_n = 1'b1;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clock);
      if (fd_n) fds++;
      if (k == 20) begin
        total++;
        if (fd_n !== 1'b1 || valid_n !== 1'b0) begin
          $display("[TB] FAIL rand_frame_done got fd=%b v=%b expected fd=1 v=0", fd_n, valid_n);
        end else passed++;
        finished = 1;
      end else begin
        if (valid_n !== 1'b1 || (hold && data_n !== hd)) begin
          total++;
          $display("[TB] FAIL rand_valid_hold k=%0d got v=%b d=%0d expected v=1 d=%0d", k, valid_n, data_n, hd);
        end
        rdy = ($urandom_range(0, 9) < 7);
        ready_n = rdy;
        if (rdy) begin
          expv = 16'(((k / 5) * 5 + (k % 5)) * 37 - 300);
          total++;
          if (data_n !== expv || row_n !== 2'(k / 5) || col_n !== 3'(k % 5) ||
              lc_n !== ((k % 5) == 4) || last_n !== (k == 19)) begin
            $display("[TB] FAIL rand_elem k=%0d got d=%0d r=%0d c=%0d lc=%b l=%b expected d=%0d r=%0d c=%0d",
                     k, data_n, row_n, col_n, lc_n, last_n, expv, k / 5, k % 5);
          end else passed++;
          k++;
        end
        hold = !rdy;
        hd = data_n;
      end
    end
    repeat (3) begin
      @(negedge clock);
      if (fd_n) fds++;
    end
    total++;
    if (k !== 20 || fds !== 1) begin
      $display("[TB] FAIL rand_count got n=%0d fd=%0d expected n=20 fd=1", k, fds);
    end else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    nreset = 1'b1;
    done_a = 1'b0; ready_a = 1'b0;
    done_r = 1'b0; ready_r = 1'b0;
    done_n = 1'b0; ready_n = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        mat_a[i][j] = 16'(i * 3 + j);
    mat_r[0][0] = -16'sd5;  mat_r[0][1] = 16'sd3;      mat_r[0][2] = -16'sd1;
    mat_r[1][0] = 16'sd0;   mat_r[1][1] = 16'sd7;      mat_r[1][2] = 16'h8000;
    mat_r[2][0] = 16'sd2;   mat_r[2][1] = -16'sd2;     mat_r[2][2] = 16'sd1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 5; j++)
        mat_n[i][j] = 16'((i * 5 + j) * 37 - 300);
    #12;
    test_reset();
    test_stream_basic();
    test_done_hold();
    test_reset_midframe();
    test_relu();
    test_random_ready();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
